// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: default widths, PC step and reset vector.
package fetch_unit_pkg;

  localparam int unsigned XlenDefault        = 32;
  localparam int unsigned InstrStep          = 4;
  localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit handshake bundle: redirect input, instruction-memory request/response and the
// decode-side output stream. The fetch unit is the master.
interface fetch_unit_if #(
  parameter int unsigned XLEN = fetch_unit_pkg::XlenDefault
) ();

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    input  redirect_valid, redirect_target,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_target,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with push, pop, flush and an occupancy count.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly PtrW bits wide, so the increment wraps modulo Depth.
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a prefetch buffer and redirect support.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise `misaligned` and halt fetching.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = XlenDefault,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(ResetVectorDefault)
) (
  input  logic         clock,
  input  logic         Reset,
  fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         misaligned
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;

  logic [XLEN-1:0]   redirect_pc;
  logic              target_misaligned;
  logic              redirect;
  logic              req_valid;
  logic              req_fire;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   occupancy;
  logic [2*XLEN-1:0] head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_misaligned = !is_aligned(bus.redirect_target[1:0]);
  assign redirect_pc       = bus.redirect_target;
  // Halt and the trap flag are set and cleared together by redirects.
  assign misaligned        = halted_q;
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^bus.redirect_target[1:0];
  assign target_misaligned = 1'b0;
  assign redirect_pc       = {bus.redirect_target[XLEN-1:2], 2'b00};
`endif

  always_comb begin
    redirect  = bus.redirect_valid && !Reset;
    // Buffered entries plus the one in flight must leave room for the next response.
    occupancy = count + CntW'(inflight_q);
    req_valid = !Reset && !redirect && !halted_q && (occupancy < CntW'(DEPTH));
    req_fire  = req_valid && bus.imem_req_ready;
    out_valid = !Reset && !redirect && (count != '0);
    pop       = out_valid && bus.out_ready;
    // A response landing in a redirect cycle belongs to the abandoned path and is dropped.
    push      = !Reset && !redirect && inflight_q && bus.imem_resp_valid;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req_fire;
    inflight_pc_d = inflight_pc_q;
    halted_d      = halted_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      halted_d   = target_misaligned;
    end else if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(InstrStep);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      fetch_pc_q    <= RESET_VECTOR;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
    end
  end

  fetch_fifo #(
    .Width (2 * XLEN),
    .Depth (DEPTH)
  ) u_fetch_fifo (
    .clk_i       (clock),
    .rst_i       (Reset),
    .push_i      (push),
    .push_data_i ({inflight_pc_q, bus.imem_resp_data}),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = head[2*XLEN-1:XLEN];
  assign bus.out_instr      = head[XLEN-1:0];

endmodule
